// File: rtl/ace_snoop_sched.sv
// ace_snoop_sched: broadcasts one coherent snoop at a time on the AC channel
// of every cached master except the initiator, then collects and merges their
// CR responses into one crresp returned to the coherency controller.
//
// Handshake rule on every channel: a transfer happens in a cycle where valid
// and ready are both high at the rising clock edge. A valid, once raised, is
// held with a stable payload until its transfer. A ready is driven only from
// registered state, never from the other side's valid.
//
// Optional feature: define ACE_SNOOP_TIMEOUT_EN to bound the CR wait. On expiry
// the error bit is set, unresponded ports are marked stale, and new requests
// are held off until every stale port's late CR has been sunk.
module ace_snoop_sched #(
    parameter int NoMasters     = 4,
    parameter int AddrWidth     = 64,
    parameter int TimeoutCycles = 1024,
    localparam int IdxW         = (NoMasters > 1) ? $clog2(NoMasters) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [AddrWidth-1:0]   req_addr_i,
    input  logic [3:0]             req_snoop_i,
    input  logic [2:0]             req_prot_i,
    input  logic [IdxW-1:0]        req_init_i,
    output logic                   resp_valid_o,
    input  logic                   resp_ready_i,
    output logic [4:0]             resp_o,
    output logic [IdxW-1:0]        resp_data_port_o,
    output logic [NoMasters-1:0]   ac_valid_o,
    input  logic [NoMasters-1:0]   ac_ready_i,
    output logic [AddrWidth-1:0]   ac_addr_o,
    output logic [3:0]             ac_snoop_o,
    output logic [2:0]             ac_prot_o,
    input  logic [NoMasters-1:0]   cr_valid_i,
    output logic [NoMasters-1:0]   cr_ready_o,
    input  logic [5*NoMasters-1:0] cr_resp_i
);

    generate
        if (NoMasters < 1 || TimeoutCycles < 1) begin : g_bad_cfg
            $error("ace_snoop_sched: NoMasters and TimeoutCycles must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BCAST   = 2'd1,
        S_COLLECT = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [NoMasters-1:0]   r_target;
    logic [NoMasters-1:0]   r_ac_done;
    logic [NoMasters-1:0]   r_cr_done;
    logic [4:0]             r_acc;
    logic [IdxW-1:0]        r_data_port;
    logic                   r_data_found;
    logic [AddrWidth-1:0]   r_addr;
    logic [3:0]             r_snoop;
    logic [2:0]             r_prot;

    logic                   w_req_hs;
    logic                   w_active;
    logic [NoMasters-1:0]   w_new_target;
    logic [NoMasters-1:0]   w_ac_hs;
    logic [NoMasters-1:0]   w_live_ready;
    logic [NoMasters-1:0]   w_live_hs;
    logic [NoMasters-1:0]   w_stale_ready;
    logic                   w_stale_any;
    logic                   w_timeout;
    logic [4:0]             w_cr_or;
    logic                   w_dp_hit;
    logic [IdxW-1:0]        w_dp_idx;

    assign w_active     = (r_state == S_BCAST) || (r_state == S_COLLECT);
    assign req_ready_o  = (r_state == S_IDLE) && !rst_i && !w_stale_any;
    assign w_req_hs     = req_valid_i && req_ready_o;
    assign ac_valid_o   = (r_state == S_BCAST) ? (r_target & ~r_ac_done) : '0;
    assign w_ac_hs      = ac_valid_o & ac_ready_i;
    assign w_live_ready = w_active ? (r_ac_done & ~r_cr_done) : '0;
    assign w_live_hs    = cr_valid_i & w_live_ready;
    assign cr_ready_o   = w_live_ready | w_stale_ready;

    assign resp_valid_o     = (r_state == S_RESP);
    assign resp_o           = r_acc;
    assign resp_data_port_o = r_data_port;
    assign ac_addr_o        = r_addr;
    assign ac_snoop_o       = r_snoop;
    assign ac_prot_o        = r_prot;

    // Target set for a new request: every port except the initiator.
    always_comb begin
        w_new_target = '0;
        for (int i = 0; i < NoMasters; i++) begin
            w_new_target[i] = (int'(req_init_i) != i);
        end
    end

    // Merge this cycle's CR handshakes; scanning downward lets the lowest
    // index with dataTransfer win when several arrive together.
    always_comb begin
        w_cr_or  = '0;
        w_dp_hit = 1'b0;
        w_dp_idx = '0;
        for (int i = NoMasters - 1; i >= 0; i--) begin
            if (w_live_hs[i]) begin
                w_cr_or = w_cr_or | cr_resp_i[5*i +: 5];
                if (cr_resp_i[5*i]) begin
                    w_dp_hit = 1'b1;
                    w_dp_idx = IdxW'(i);
                end
            end
        end
    end

`ifdef ACE_SNOOP_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);

    logic [NoMasters-1:0]   r_stale;
    logic [CntW-1:0]        r_tmo_cnt;

    assign w_stale_ready = r_stale;
    assign w_stale_any   = |r_stale;
    assign w_timeout     = (r_state == S_COLLECT) && (w_live_hs == '0) &&
                           (r_tmo_cnt == CntW'(TimeoutCycles - 1));

    // Idle-progress counter in COLLECT plus stale tracking; a stale port's
    // late CR is accepted and dropped, clearing its stale bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tmo_cnt <= '0;
            r_stale   <= '0;
        end else begin
            if (r_state != S_COLLECT || w_live_hs != '0) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            r_stale <= (r_stale & ~cr_valid_i) |
                       (w_timeout ? (r_target & ~r_cr_done) : '0);
        end
    end
`else
    assign w_stale_ready = '0;
    assign w_stale_any   = 1'b0;
    assign w_timeout     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req_hs) begin
                    w_state_nxt = (w_new_target != '0) ? S_BCAST : S_RESP;
                end
            end
            S_BCAST: begin
                if (((r_ac_done | w_ac_hs) & r_target) == r_target) begin
                    w_state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if ((((r_cr_done | w_live_hs) & r_target) == r_target) || w_timeout) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request capture, progress masks and the response accumulator.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_target     <= '0;
            r_ac_done    <= '0;
            r_cr_done    <= '0;
            r_acc        <= '0;
            r_data_port  <= '0;
            r_data_found <= 1'b0;
            r_addr       <= '0;
            r_snoop      <= '0;
            r_prot       <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_req_hs) begin
                r_addr       <= req_addr_i;
                r_snoop      <= req_snoop_i;
                r_prot       <= req_prot_i;
                r_target     <= w_new_target;
                r_ac_done    <= '0;
                r_cr_done    <= '0;
                r_acc        <= '0;
                r_data_port  <= '0;
                r_data_found <= 1'b0;
            end
        end else if (w_active) begin
            r_ac_done <= r_ac_done | w_ac_hs;
            r_cr_done <= r_cr_done | w_live_hs;
            r_acc     <= r_acc | w_cr_or | (w_timeout ? 5'b00010 : 5'b00000);
            if (w_dp_hit && !r_data_found) begin
                r_data_found <= 1'b1;
                r_data_port  <= w_dp_idx;
            end
        end
    end

endmodule

// File: tb/tb_ace_snoop_sched.sv
// Bench for ace_snoop_sched: a 4-port instance driven by directed and random
// snoop transactions against a per-port timing/merge model, plus a 1-port
// instance for the empty-target case.
module tb_ace_snoop_sched;

    localparam int N  = 4;
    localparam int AW = 64;

    logic           clk = 1'b0;
    logic           rst;
    always #5 clk = ~clk;

    logic           req_valid;
    logic           req_ready;
    logic [AW-1:0]  req_addr;
    logic [3:0]     req_snoop;
    logic [2:0]     req_prot;
    logic [1:0]     req_init;
    logic           resp_valid;
    logic           resp_ready;
    logic [4:0]     resp;
    logic [1:0]     resp_dp;
    logic [N-1:0]   ac_valid;
    logic [N-1:0]   ac_ready;
    logic [AW-1:0]  ac_addr;
    logic [3:0]     ac_snoop;
    logic [2:0]     ac_prot;
    logic [N-1:0]   cr_valid;
    logic [N-1:0]   cr_ready;
    logic [5*N-1:0] cr_resp;

    logic           s_req_valid;
    logic           s_req_ready;
    logic [0:0]     s_req_init;
    logic           s_resp_valid;
    logic           s_resp_ready;
    logic [4:0]     s_resp;
    logic [0:0]     s_resp_dp;
    logic [0:0]     s_ac_valid;
    logic [0:0]     s_ac_ready;
    logic [AW-1:0]  s_ac_addr;
    logic [3:0]     s_ac_snoop;
    logic [2:0]     s_ac_prot;
    logic [0:0]     s_cr_valid;
    logic [0:0]     s_cr_ready;
    logic [4:0]     s_cr_resp;

    int checks = 0;
    int errors = 0;

    int         t_ac_dly[N];
    int         t_cr_dly[N];
    logic [4:0] t_cr_val[N];

    ace_snoop_sched #(.NoMasters(N), .AddrWidth(AW), .TimeoutCycles(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_snoop_i(req_snoop), .req_prot_i(req_prot),
        .req_init_i(req_init),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_o(resp), .resp_data_port_o(resp_dp),
        .ac_valid_o(ac_valid), .ac_ready_i(ac_ready),
        .ac_addr_o(ac_addr), .ac_snoop_o(ac_snoop), .ac_prot_o(ac_prot),
        .cr_valid_i(cr_valid), .cr_ready_o(cr_ready), .cr_resp_i(cr_resp)
    );

    ace_snoop_sched #(.NoMasters(1), .AddrWidth(AW), .TimeoutCycles(16)) dut_single (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(s_req_valid), .req_ready_o(s_req_ready),
        .req_addr_i(req_addr), .req_snoop_i(req_snoop), .req_prot_i(req_prot),
        .req_init_i(s_req_init),
        .resp_valid_o(s_resp_valid), .resp_ready_i(s_resp_ready),
        .resp_o(s_resp), .resp_data_port_o(s_resp_dp),
        .ac_valid_o(s_ac_valid), .ac_ready_i(s_ac_ready),
        .ac_addr_o(s_ac_addr), .ac_snoop_o(s_ac_snoop), .ac_prot_o(s_ac_prot),
        .cr_valid_i(s_cr_valid), .cr_ready_o(s_cr_ready), .cr_resp_i(s_cr_resp)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One snoop transaction on the 4-port DUT. Per port i (if targeted):
    // AC ready from cycle a=1+ac_dly, CR driven for one cycle at c=a+1+cr_dly.
    // Response expected at max(c)+1 (or cycle 1 for an empty target set).
    task automatic run_txn(input string name, input int init, input logic [AW-1:0] addr,
                           input logic [3:0] snp, input logic [2:0] prot, input int hold);
        int         a_cyc[N];
        int         c_cyc[N];
        logic [N-1:0] tgt;
        logic [N-1:0] exp_acv;
        logic [N-1:0] exp_crr;
        logic [4:0] exp_resp;
        int         r_cyc;
        int         exp_dp;
        int         best;
        bit         got;
        exp_resp = '0;
        r_cyc    = 1;
        for (int i = 0; i < N; i++) begin
            tgt[i]   = (i != init);
            a_cyc[i] = 1 + t_ac_dly[i];
            c_cyc[i] = a_cyc[i] + 1 + t_cr_dly[i];
            if (tgt[i]) begin
                exp_resp = exp_resp | t_cr_val[i];
                if (c_cyc[i] + 1 > r_cyc) r_cyc = c_cyc[i] + 1;
            end
        end
        exp_dp = -1;
        best   = 1 << 30;
        for (int i = 0; i < N; i++) begin
            if (tgt[i] && t_cr_val[i][0] && c_cyc[i] < best) begin
                best   = c_cyc[i];
                exp_dp = i;
            end
        end

        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (req_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s req_ready wait: got %b required 1 within 50 cycles", name, req_ready);
            return;
        end
        req_valid = 1'b1;
        req_addr  = addr;
        req_snoop = snp;
        req_prot  = prot;
        req_init  = 2'(init);
        tick();

        for (int c = 1; c <= r_cyc; c++) begin
            for (int i = 0; i < N; i++) begin
                ac_ready[i] = tgt[i] ? (c >= a_cyc[i]) : 1'($urandom_range(0, 1));
                cr_valid[i] = tgt[i] ? (c == c_cyc[i]) : 1'($urandom_range(0, 1));
                cr_resp[5*i +: 5] = (tgt[i] && c == c_cyc[i]) ? t_cr_val[i] : 5'($urandom);
                exp_acv[i] = tgt[i] && (c <= a_cyc[i]);
                exp_crr[i] = tgt[i] && (c > a_cyc[i]) && (c <= c_cyc[i]);
            end
            req_valid = 1'($urandom_range(0, 1));
            req_addr  = {$urandom, $urandom};
            req_snoop = 4'($urandom);
            req_prot  = 3'($urandom);
            #1;
            checks++;
            if (ac_valid !== exp_acv) begin
                errors++;
                $display("FAIL %s ac_valid c=%0d: got %b required %b", name, c, ac_valid, exp_acv);
            end
            checks++;
            if (cr_ready !== exp_crr) begin
                errors++;
                $display("FAIL %s cr_ready c=%0d: got %b required %b", name, c, cr_ready, exp_crr);
            end
            checks++;
            if (resp_valid !== (c == r_cyc)) begin
                errors++;
                $display("FAIL %s resp_valid c=%0d: got %b required %b", name, c, resp_valid, (c == r_cyc));
            end
            checks++;
            if (req_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s req_ready busy c=%0d: got %b required 0", name, c, req_ready);
            end
            if (ac_valid != '0) begin
                checks++;
                if (ac_addr !== addr || ac_snoop !== snp || ac_prot !== prot) begin
                    errors++;
                    $display("FAIL %s ac payload c=%0d: got %h/%h/%h required %h/%h/%h",
                             name, c, ac_addr, ac_snoop, ac_prot, addr, snp, prot);
                end
            end
            if (c < r_cyc) tick();
        end

        checks++;
        if (resp !== exp_resp) begin
            errors++;
            $display("FAIL %s resp: got %h required %h", name, resp, exp_resp);
        end
        if (exp_dp >= 0) begin
            checks++;
            if (int'(resp_dp) != exp_dp) begin
                errors++;
                $display("FAIL %s data_port: got %0d required %0d", name, resp_dp, exp_dp);
            end
        end

        for (int h = 0; h <= hold; h++) begin
            resp_ready = (h == hold);
            cr_valid   = N'($urandom);
            cr_resp    = (5*N)'({$urandom, $urandom});
            req_valid  = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (resp_valid !== 1'b1 || resp !== exp_resp || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s resp hold h=%0d: got v=%b r=%h rdy=%b required v=1 r=%h rdy=0",
                         name, h, resp_valid, resp, req_ready, exp_resp);
            end
            tick();
        end
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        cr_valid   = '0;
        ac_ready   = '0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || ac_valid !== '0) begin
            errors++;
            $display("FAIL %s after resp: got v=%b rdy=%b acv=%b required v=0 rdy=1 acv=0",
                     name, resp_valid, req_ready, ac_valid);
        end
    endtask

    task automatic set_port(input int i, input int ad, input int cd, input logic [4:0] v);
        t_ac_dly[i] = ad;
        t_cr_dly[i] = cd;
        t_cr_val[i] = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 0; req_addr = '0; req_snoop = '0; req_prot = '0; req_init = '0;
        resp_ready = 0; ac_ready = '0; cr_valid = '0; cr_resp = '0;
        s_req_valid = 0; s_req_init = '0; s_resp_ready = 0; s_ac_ready = '0;
        s_cr_valid = '0; s_cr_resp = '0;
        tick();
        tick();
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || ac_valid !== '0 || cr_ready !== '0) begin
            errors++;
            $display("FAIL reset ctrl: got rdy=%b rv=%b acv=%b crr=%b required all 0",
                     req_ready, resp_valid, ac_valid, cr_ready);
        end
        checks++;
        if (resp !== '0 || resp_dp !== '0 || ac_addr !== '0 || ac_snoop !== '0 || ac_prot !== '0) begin
            errors++;
            $display("FAIL reset data: got resp=%h dp=%0d addr=%h snp=%h prot=%h required 0",
                     resp, resp_dp, ac_addr, ac_snoop, ac_prot);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || s_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset release: got rdy=%b s_rdy=%b required 1/1", req_ready, s_req_ready);
        end
        tick();
    endtask

    task automatic test_basic();
        set_port(0, 0, 0, 5'h1F);
        set_port(1, 0, 0, 5'h00);
        set_port(2, 0, 0, 5'h08);
        set_port(3, 0, 0, 5'h0D);
        run_txn("basic", 0, 64'h1000, 4'b0001, 3'b010, 0);
    endtask

    task automatic test_staggered();
        set_port(0, 0, 0, 5'h02);
        set_port(1, 0, 0, 5'h08);
        set_port(2, 5, 0, 5'h11);
        set_port(3, 1, 2, 5'h00);
        run_txn("staggered", 0, 64'hDEAD_BEEF_0000_2040, 4'b0111, 3'b001, 0);
    endtask

    task automatic test_simul_data();
        set_port(0, 0, 0, 5'h00);
        set_port(1, 0, 1, 5'h05);
        set_port(2, 0, 1, 5'h08);
        set_port(3, 0, 1, 5'h11);
        run_txn("simul_data", 0, 64'h3000, 4'b1111, 3'b000, 0);
        set_port(0, 0, 2, 5'h01);
        set_port(1, 0, 0, 5'h00);
        set_port(2, 2, 0, 5'h01);
        set_port(3, 0, 0, 5'h00);
        run_txn("late_data", 3, 64'h4000, 4'b1110, 3'b111, 0);
    endtask

    task automatic test_resp_hold();
        set_port(0, 0, 0, 5'h04);
        set_port(1, 1, 0, 5'h10);
        set_port(2, 0, 3, 5'h00);
        set_port(3, 0, 0, 5'h09);
        run_txn("resp_hold", 1, 64'h5000, 4'b0010, 3'b011, 10);
        set_port(0, 0, 0, 5'h01);
        run_txn("back_to_back", 2, 64'h5040, 4'b0001, 3'b000, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < N; i++) begin
                set_port(i, $urandom_range(0, 5), $urandom_range(0, 5), 5'($urandom));
            end
            run_txn("random", $urandom_range(0, N - 1), {$urandom, $urandom},
                    4'($urandom), 3'($urandom), $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < N; i++) set_port(i, 8, 0, 5'h1F);
        req_valid = 1'b1;
        req_addr  = 64'h7000;
        req_snoop = 4'b0011;
        req_prot  = 3'b101;
        req_init  = 2'd1;
        tick();
        req_valid = 1'b0;
        #1;
        checks++;
        if (ac_valid !== 4'b1101) begin
            errors++;
            $display("FAIL reset_mid pre: got acv=%b required 1101", ac_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ac_valid !== '0 || cr_ready !== '0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got acv=%b crr=%b rv=%b rdy=%b required all 0",
                     ac_valid, cr_ready, resp_valid, req_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || ac_addr !== '0 || resp !== '0) begin
            errors++;
            $display("FAIL reset_mid release: got rdy=%b addr=%h resp=%h required 1/0/0",
                     req_ready, ac_addr, resp);
        end
        tick();
        for (int i = 0; i < N; i++) set_port(i, 0, 0, 5'(i * 3));
        run_txn("after_reset", 0, 64'h7100, 4'b0000, 3'b000, 0);
    endtask

    task automatic test_single_master();
        s_req_valid = 1'b1;
        s_req_init  = 1'b0;
        s_cr_valid  = 1'b1;
        s_cr_resp   = 5'h1F;
        s_ac_ready  = 1'b1;
        #1;
        checks++;
        if (s_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL single ready: got %b required 1", s_req_ready);
        end
        tick();
        s_req_valid = 1'b0;
        #1;
        checks++;
        if (s_resp_valid !== 1'b1 || s_resp !== 5'h00 || s_ac_valid !== 1'b0 ||
            s_cr_ready !== 1'b0 || s_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL single resp: got rv=%b resp=%h acv=%b crr=%b rdy=%b required 1/00/0/0/0",
                     s_resp_valid, s_resp, s_ac_valid, s_cr_ready, s_req_ready);
        end
        s_resp_ready = 1'b1;
        tick();
        s_resp_ready = 1'b0;
        s_cr_valid   = 1'b0;
        s_ac_ready   = 1'b0;
        #1;
        checks++;
        if (s_resp_valid !== 1'b0 || s_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL single done: got rv=%b rdy=%b required 0/1", s_resp_valid, s_req_ready);
        end
    endtask

`ifdef ACE_SNOOP_TIMEOUT_EN
    task automatic test_timeout();
        bit got;
        req_valid = 1'b1;
        req_addr  = 64'h9000;
        req_snoop = 4'b0001;
        req_prot  = 3'b000;
        req_init  = 2'd0;
        tick();
        req_valid = 1'b0;
        ac_ready  = '1;
        tick();
        ac_ready  = '0;
        cr_valid  = 4'b1010;
        cr_resp   = {5'h05, 5'h00, 5'h08, 5'h00};
        tick();
        cr_valid  = '0;
        got = 1'b0;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (resp_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!got || resp !== 5'h0F) begin
            errors++;
            $display("FAIL timeout resp: got seen=%b resp=%h required 1/0f", got, resp);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (req_ready !== 1'b0 || cr_ready !== 4'b0100) begin
                errors++;
                $display("FAIL timeout stale k=%0d: got rdy=%b crr=%b required 0/0100", k, req_ready, cr_ready);
            end
            tick();
        end
        cr_valid = 4'b0100;
        cr_resp  = {5'h00, 5'h1F, 5'h00, 5'h00};
        tick();
        cr_valid = '0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || cr_ready !== '0) begin
            errors++;
            $display("FAIL timeout sunk: got rdy=%b crr=%b required 1/0000", req_ready, cr_ready);
        end
        for (int i = 0; i < N; i++) set_port(i, 0, 0, 5'h00);
        run_txn("after_timeout", 0, 64'h9100, 4'b0001, 3'b000, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_staggered();
        test_simul_data();
        test_resp_hold();
        test_single_master();
        test_random();
        test_reset_mid();
`ifdef ACE_SNOOP_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
